// File: rtl/tpu_cmd_pkg.sv
// Shared constants and types for the TPU command-path register interface.
package tpu_cmd_pkg;

   localparam logic [3:0] CMD_LO = 4'h0;
   localparam logic [3:0] CMD_HI = 4'h4;
   localparam logic [3:0] STATUS = 4'h8;
   localparam logic [3:0] POPCNT = 4'hC;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int STAT_EMPTY    = 0;
   localparam int STAT_FULL     = 1;
   localparam int STAT_OVF      = 2;
   localparam int STAT_IRQ      = 3;
   localparam int STAT_FILL_LSB = 8;

   typedef logic [63:0] tpu_cmd_t;

   // Byte-lane merge of a 32-bit write into an existing register value.
   function automatic logic [31:0] strb_merge(input logic [31:0] cur,
                                              input logic [31:0] data,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      res = cur;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/tpu_cmd_fifo.sv
// Synchronous FIFO with fill level; pushes when full and pops when empty are ignored.
module tpu_cmd_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   fill
);

   localparam int AW     = $clog2(DEPTH);
   localparam int FILL_W = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full      = (fill == FILL_W'(DEPTH));
   assign empty     = (fill == '0);
   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;
   assign head_data = mem[rd_ptr];

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   fill <= fill + FILL_W'(1);
            2'b01:   fill <= fill - FILL_W'(1);
            default: fill <= fill;
         endcase
      end
   end

endmodule

// File: rtl/tpu_cmd_axil_regif.sv
// AXI4-Lite register front end for the TPU instruction FIFO.
// Optional build macro: TPU_CMD_DRAIN_IRQ_EN adds a drain-complete irq output.
module tpu_cmd_axil_regif
   import tpu_cmd_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int FIFO_DEPTH         = 8,
   parameter int CMD_WIDTH          = 64
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [CMD_WIDTH-1:0]            cmd_data,
   output logic                            cmd_valid,
   input  logic                            cmd_ready
`ifdef TPU_CMD_DRAIN_IRQ_EN
   ,
   output logic                            irq
`endif
);

   localparam int FILL_W = $clog2(FIFO_DEPTH) + 1;

   logic [31:0]       cmd_lo;
   logic [31:0]       cmd_hi;
   logic [31:0]       popcnt;
   logic              ovf;
   logic [31:0]       lo_merged;
   logic [31:0]       hi_merged;
   logic [31:0]       status_word;
   logic [31:0]       rd_word;
   logic [3:0]        wr_off;
   logic [3:0]        rd_off;
   logic              wr_fire;
   logic              rd_fire;
   logic              push;
   logic              pop;
   logic              full;
   logic              empty;
   logic [FILL_W-1:0] fill;
   tpu_cmd_t          push_data;
   logic              unused_in;

   assign unused_in = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   assign wr_off  = {S_AXI_AWADDR[3:2], 2'b00};
   assign rd_off  = {S_AXI_ARADDR[3:2], 2'b00};
   // Ready is held low in reset even if a master misbehaves and drives valid.
   assign wr_fire = S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID && S_AXI_ARESETN;
   assign rd_fire = S_AXI_ARVALID && !S_AXI_RVALID && S_AXI_ARESETN;

   assign S_AXI_AWREADY = wr_fire;
   assign S_AXI_WREADY  = wr_fire;
   assign S_AXI_ARREADY = rd_fire;
   assign S_AXI_RRESP   = RESP_OKAY;

   assign lo_merged = strb_merge(cmd_lo, S_AXI_WDATA, S_AXI_WSTRB);
   assign hi_merged = strb_merge(cmd_hi, S_AXI_WDATA, S_AXI_WSTRB);
   assign push_data = {hi_merged, cmd_lo};
   // Full is the pre-edge state, so a concurrent pop cannot make room for this push.
   assign push      = wr_fire && (wr_off == CMD_HI) && !full;
   assign cmd_valid = !empty;
   assign pop       = cmd_valid && cmd_ready;

   tpu_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (CMD_WIDTH)
   ) u_fifo (
      .clk       (S_AXI_ACLK),
      .rst_n     (S_AXI_ARESETN),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head_data (cmd_data),
      .full      (full),
      .empty     (empty),
      .fill      (fill)
   );

`ifdef TPU_CMD_DRAIN_IRQ_EN
   logic irq_set;
   logic irq_clr;

   assign irq_set = pop && (fill == FILL_W'(1)) && !push;
   assign irq_clr = wr_fire && (wr_off == STATUS) && S_AXI_WSTRB[0] && S_AXI_WDATA[STAT_IRQ];

   // Drain interrupt: a new drain event outranks a simultaneous clear.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN)  irq <= 1'b0;
      else if (irq_set)    irq <= 1'b1;
      else if (irq_clr)    irq <= 1'b0;
   end
`endif

   // STATUS composition; fill is zero-extended into its byte field.
   always_comb begin
      status_word                       = '0;
      status_word[STAT_EMPTY]           = empty;
      status_word[STAT_FULL]            = full;
      status_word[STAT_OVF]             = ovf;
      status_word[STAT_FILL_LSB +: 8]   = 8'(fill);
`ifdef TPU_CMD_DRAIN_IRQ_EN
      status_word[STAT_IRQ]             = irq;
`endif
   end

   // Read mux, sampled into RDATA at address acceptance.
   always_comb begin
      rd_word = '0;
      case (rd_off)
         CMD_LO:  rd_word = cmd_lo;
         CMD_HI:  rd_word = cmd_hi;
         STATUS:  rd_word = status_word;
         POPCNT:  rd_word = popcnt;
         default: rd_word = '0;
      endcase
   end

   // Write channel: register updates, push overflow handling and B response.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         S_AXI_BVALID <= 1'b0;
         S_AXI_BRESP  <= RESP_OKAY;
         cmd_lo       <= '0;
         cmd_hi       <= '0;
         ovf          <= 1'b0;
      end else if (wr_fire) begin
         S_AXI_BVALID <= 1'b1;
         S_AXI_BRESP  <= RESP_OKAY;
         case (wr_off)
            CMD_LO: cmd_lo <= lo_merged;
            CMD_HI: begin
               cmd_hi <= hi_merged;
               if (full) begin
                  ovf         <= 1'b1;
                  S_AXI_BRESP <= RESP_SLVERR;
               end
            end
            STATUS: if (S_AXI_WSTRB[0] && S_AXI_WDATA[STAT_OVF]) ovf <= 1'b0;
            default: ;
         endcase
      end else if (S_AXI_BVALID && S_AXI_BREADY) begin
         S_AXI_BVALID <= 1'b0;
      end
   end

   // Read channel: data captured at acceptance and held until RREADY.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         S_AXI_RVALID <= 1'b0;
         S_AXI_RDATA  <= '0;
      end else if (rd_fire) begin
         S_AXI_RVALID <= 1'b1;
         S_AXI_RDATA  <= rd_word;
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
         S_AXI_RVALID <= 1'b0;
      end
   end

   // Popped-instruction counter, wrapping at 2^32.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) popcnt <= '0;
      else if (pop)       popcnt <= popcnt + 32'd1;
   end

endmodule
